// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - programmable countdown timer controller (optional TICK_PRESCALE_EN prescaler)
module countdown_ctrl #(
    parameter int N        = 5,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    input  logic         auto_reload,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         paused,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [N-1:0] count_next;
    logic         done_next;
    logic         tick;
    logic         load_nz;

    if (PRESCALE < 2 || PRESCALE > 255) begin : g_bad_prescale
        $error("countdown_ctrl: PRESCALE out of range");
    end

`ifdef TICK_PRESCALE_EN
    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);
    logic [7:0] presc, presc_next;
    assign tick = (presc == PRESC_LAST);
`else
    assign tick = 1'b1;
`endif

    assign load_nz = (load_val != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
`ifdef TICK_PRESCALE_EN
            presc <= '0;
`endif
        end else begin
            state <= state_next;
            count <= count_next;
            done  <= done_next;
`ifdef TICK_PRESCALE_EN
            presc <= presc_next;
`endif
        end
    end

    // Priority: abort > start > pause > counting
    always_comb begin
        state_next = state;
        count_next = count;
        done_next  = 1'b0;
`ifdef TICK_PRESCALE_EN
        presc_next = presc;
`endif
        if (abort) begin
            state_next = IDLE;
            count_next = '0;
`ifdef TICK_PRESCALE_EN
            presc_next = '0;
`endif
        end else if (start) begin
`ifdef TICK_PRESCALE_EN
            presc_next = '0;
`endif
            if (load_nz) begin
                count_next = load_val;
                state_next = RUN;
            end else begin
                count_next = '0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (tick) begin
`ifdef TICK_PRESCALE_EN
                        presc_next = '0;
`endif
                        if (count > N'(1)) begin
                            count_next = count - N'(1);
                        end else if (count == N'(1)) begin
                            count_next = '0;
                            done_next  = 1'b1;
                        end else if (auto_reload && load_nz) begin
                            count_next = load_val;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
`ifdef TICK_PRESCALE_EN
                        presc_next = presc + 8'd1;
`endif
                    end
                end
                PAUSED: begin
                    if (!pause) state_next = RUN;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign busy   = (state == RUN) || (state == PAUSED);
    assign paused = (state == PAUSED);

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed self-checking bench for countdown_ctrl
module tb_countdown_ctrl;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] load_val;
    logic         start, pause, abort, auto_reload;
    logic [N-1:0] count;
    logic         busy, paused, done;

    int checks = 0;
    int errors = 0;

    countdown_ctrl #(.N(N), .PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .load_val(load_val), .start(start),
        .pause(pause), .abort(abort), .auto_reload(auto_reload),
        .count(count), .busy(busy), .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int c, input int b, input int p, input int d);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".busy"}, int'(busy), b);
        check({tag, ".paused"}, int'(paused), p);
        check({tag, ".done"}, int'(done), d);
    endtask

    initial begin
        reset = 1'b1; load_val = 5'd9; start = 1'b1; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
        tick(); tick();
        chk_out("reset_hold_start", 0, 0, 0, 0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk_out("idle", 0, 0, 0, 0);

        // one-shot load 5
        load_val = 5'd5; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("os_load", 5, 1, 0, 0);
        for (int i = 4; i >= 1; i--) begin
            tick();
            chk_out("os_dec", i, 1, 0, 0);
        end
        tick(); chk_out("os_done", 0, 1, 0, 1);
        tick(); chk_out("os_idle", 0, 0, 0, 0);

        // auto-reload load 3
        load_val = 5'd3; auto_reload = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("ar_load", 3, 1, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk_out("ar_seq", 3 - (k % 4), 1, 0, ((k % 4) == 3) ? 1 : 0);
            if (k == 8) auto_reload = 1'b0;
        end
        tick(); chk_out("ar_stop", 0, 0, 0, 0);

        // pause / resume with load 10
        load_val = 5'd10; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("pz_load", 10, 1, 0, 0);
        for (int i = 9; i >= 6; i--) begin
            tick(); check("pz_dec", int'(count), i);
        end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("pz_hold", 6, 1, 1, 0);
        end
        pause = 1'b0;
        tick(); chk_out("pz_resume", 6, 1, 0, 0);
        for (int i = 5; i >= 1; i--) begin
            tick(); check("pz_dec2", int'(count), i);
        end
        pause = 1'b1;
        tick(); chk_out("pz_at1", 1, 1, 1, 0);
        tick(); chk_out("pz_at1b", 1, 1, 1, 0);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk_out("pz_abort", 0, 0, 0, 0);
        pause = 1'b0;

        // abort mid-count
        load_val = 5'd8; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 7; i >= 4; i--) tick();
        check("ab_pre", int'(count), 4);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk_out("ab_run", 0, 0, 0, 0);

        // start and abort together
        start = 1'b1;
        tick(); start = 1'b0;
        check("sa_pre", int'(count), 8);
        start = 1'b1; abort = 1'b1;
        tick(); start = 1'b0; abort = 1'b0;
        chk_out("sa_both", 0, 0, 0, 0);

        // retrigger at count 2
        start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 7; i >= 2; i--) tick();
        check("rt_pre", int'(count), 2);
        load_val = 5'd7; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("rt_load", 7, 1, 0, 0);
        tick(); check("rt_dec", int'(count), 6);

        // start with zero while running, then from idle
        load_val = 5'd0; start = 1'b1;
        tick();
        chk_out("z_run", 0, 0, 0, 1);
        tick(); start = 1'b0;
        chk_out("z_idle", 0, 0, 0, 1);
        tick(); chk_out("z_after", 0, 0, 0, 0);

        // asynchronous reset mid-count
        load_val = 5'd10; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        check("rs_pre", int'(count), 9);
        #3 reset = 1'b1;
        #1 chk_out("rs_async", 0, 0, 0, 0);
        start = 1'b1;
        tick(); tick();
        chk_out("rs_start_held", 0, 0, 0, 0);
        reset = 1'b0; start = 1'b0;
        tick(); chk_out("rs_release", 0, 0, 0, 0);

`ifdef TICK_PRESCALE_EN
        load_val = 5'd2; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("ps_load", 2, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_out("ps_seq", 2 - (k / 4), 1, 0, (k == 8) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) tick();
        chk_out("ps_idle", 0, 0, 0, 0);
        load_val = 5'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk_out("ps_zero", 0, 0, 0, 1);
        tick(); chk_out("ps_zero_after", 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
